dma_priority_resolver: RTL and testbench

Channel request and priority stage of the 8237-style DMA controller. It sits directly upstream of the timing-and-control state machine. It qualifies the four DREQ inputs against mask, software-request and command settings, then runs the HRQ/HLDA bus-hold handshake with the CPU. It picks one winning channel under fixed or rotating priority and holds DACK and the channel grant until timing-and-control reports that service is done.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_priority_arbiter.sv | 30 +++
 rtl/dma_priority_resolver.sv | 101 ++++++++++
 tb/tb_dma_priority_resolver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA channel request/priority stage
package dma_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = $clog2(NUM_CH);

   // Command-register bit positions feeding the resolver's control inputs
   localparam int CMD_DISABLE   = 2;
   localparam int CMD_ROTATE    = 4;
   localparam int CMD_DREQ_LOW  = 6;
   localparam int CMD_DACK_HIGH = 7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD_REQ = 2'd1,
      SERVICE  = 2'd2
   } resolver_state_e;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
      logic [NUM_CH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - combinational fixed/rotating priority pick among effective requests
module dma_priority_arbiter
   import dma_pkg::*;
(
   input  logic [NUM_CH-1:0] i_req_eff,
   input  logic [CH_W-1:0]   i_low_pri,
   input  logic              i_rotating_pri,
   output logic              o_winner_valid,
   output logic [CH_W-1:0]   o_winner_ch
);

   logic [CH_W-1:0] w_start;
   logic [CH_W-1:0] w_idx;

   // Scan starts one past the lowest-priority channel; CH_W-bit wrap gives mod NUM_CH
   always_comb begin
      w_start        = i_rotating_pri ? CH_W'(i_low_pri + 1'b1) : '0;
      w_idx          = '0;
      o_winner_valid = 1'b0;
      o_winner_ch    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_idx = w_start + CH_W'(k);
         if (!o_winner_valid && i_req_eff[w_idx]) begin
            o_winner_valid = 1'b1;
            o_winner_ch    = w_idx;
         end
      end
   end

endmodule

// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - DREQ qualification, HRQ/HLDA handshake and channel grant sequencing
module dma_priority_resolver
   import dma_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              HLDA,
   input  logic [NUM_CH-1:0] maskReg,
   input  logic [NUM_CH-1:0] requestReg,
   input  logic              ctrlDisable,
   input  logic              rotatingPri,
   input  logic              dreqSenseLow,
   input  logic              dackSenseHigh,
   input  logic              serviceDone,
   input  logic              tcReached,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              grantValid,
   output logic [CH_W-1:0]   grantCh,
   output logic [NUM_CH-1:0] reqClear
);

   resolver_state_e   r_state;
   logic              r_hrq;
   logic              r_grant_valid;
   logic [CH_W-1:0]   r_grant_ch;
   logic [NUM_CH-1:0] r_ack;
   logic [NUM_CH-1:0] r_req_clear;
   logic [CH_W-1:0]   r_low_pri;

   logic [NUM_CH-1:0] w_req_eff;
   logic              w_winner_valid;
   logic [CH_W-1:0]   w_winner_ch;

   // Software requests bypass the mask; disable blocks everything
   assign w_req_eff = ctrlDisable ? '0
                    : (((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg);

   dma_priority_arbiter u_arbiter (
      .i_req_eff      (w_req_eff),
      .i_low_pri      (r_low_pri),
      .i_rotating_pri (rotatingPri),
      .o_winner_valid (w_winner_valid),
      .o_winner_ch    (w_winner_ch)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= IDLE;
         r_hrq         <= 1'b0;
         r_grant_valid <= 1'b0;
         r_grant_ch    <= '0;
         r_ack         <= '0;
         r_req_clear   <= '0;
         r_low_pri     <= CH_W'(NUM_CH - 1);
      end else begin
         r_req_clear <= '0;
         case (r_state)
            IDLE: begin
               if (w_winner_valid) begin
                  r_grant_ch <= w_winner_ch;
                  r_hrq      <= 1'b1;
                  r_state    <= HOLD_REQ;
               end
            end
            HOLD_REQ: begin
               if (HLDA) begin
                  r_ack         <= ch_onehot(r_grant_ch);
                  r_grant_valid <= 1'b1;
                  r_state       <= SERVICE;
               end else if (!w_req_eff[r_grant_ch]) begin
                  r_hrq   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            SERVICE: begin
               if (serviceDone || !HLDA) begin
                  r_hrq         <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_ack         <= '0;
                  r_state       <= IDLE;
               end
               // An HLDA drop without serviceDone is an abort: no rotation, no clear
               if (serviceDone) begin
                  if (rotatingPri) r_low_pri <= r_grant_ch;
                  if (tcReached) r_req_clear <= ch_onehot(r_grant_ch);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign HRQ        = r_hrq;
   assign grantValid = r_grant_valid;
   assign grantCh    = r_grant_ch;
   assign reqClear   = r_req_clear;
   assign DACK       = dackSenseHigh ? r_ack : ~r_ack;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb/tb_dma_priority_resolver.sv - scoreboard bench for dma_priority_resolver
module tb_dma_priority_resolver;
   import dma_pkg::*;

   logic              CLK;
   logic              RESET;
   logic [NUM_CH-1:0] DREQ;
   logic              HLDA;
   logic [NUM_CH-1:0] maskReg;
   logic [NUM_CH-1:0] requestReg;
   logic              ctrlDisable;
   logic              rotatingPri;
   logic              dreqSenseLow;
   logic              dackSenseHigh;
   logic              serviceDone;
   logic              tcReached;
   logic              HRQ;
   logic [NUM_CH-1:0] DACK;
   logic              grantValid;
   logic [CH_W-1:0]   grantCh;
   logic [NUM_CH-1:0] reqClear;

   int n_tests = 0;
   int n_fail  = 0;
   logic [CH_W-1:0] exp_q[$];

   dma_priority_resolver dut (
      .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .maskReg(maskReg),
      .requestReg(requestReg), .ctrlDisable(ctrlDisable), .rotatingPri(rotatingPri),
      .dreqSenseLow(dreqSenseLow), .dackSenseHigh(dackSenseHigh),
      .serviceDone(serviceDone), .tcReached(tcReached), .HRQ(HRQ), .DACK(DACK),
      .grantValid(grantValid), .grantCh(grantCh), .reqClear(reqClear)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; DREQ = '0; HLDA = 1'b0; maskReg = '0; requestReg = '0;
      ctrlDisable = 1'b0; rotatingPri = 1'b0; dreqSenseLow = 1'b0; dackSenseHigh = 1'b0;
      serviceDone = 1'b0; tcReached = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   // Waits for HRQ, acknowledges after hd cycles, holds service, then ends it
   task automatic run_service(input int hd, input int hold, input logic tc,
                              output logic ok, output logic [CH_W-1:0] ch,
                              output logic [NUM_CH-1:0] dack);
      int n;
      ok = 1'b0; ch = '0; dack = '0; n = 0;
      while (HRQ !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      if (HRQ !== 1'b1) return;
      repeat (hd) @(negedge CLK);
      HLDA = 1'b1;
      @(negedge CLK);
      if (grantValid !== 1'b1) return;
      ch = grantCh; dack = DACK;
      repeat (hold) begin
         @(negedge CLK);
         if (grantValid !== 1'b1 || DACK !== dack || HRQ !== 1'b1) return;
      end
      ok = 1'b1;
      serviceDone = 1'b1; tcReached = tc;
      @(negedge CLK);
      serviceDone = 1'b0; tcReached = 1'b0; HLDA = 1'b0;
   endtask

   task automatic pop_cmp(input string name, input logic ok, input logic [CH_W-1:0] ch);
      logic [CH_W-1:0] e;
      n_tests++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (!ok || ch !== e) begin
         n_fail++;
         $display("FAIL %s: ok=%0b grantCh=%0d expected %0d", name, ok, ch, e);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({HRQ, grantValid, grantCh, reqClear, DACK} !== {1'b0, 1'b0, 2'd0, 4'b0000, 4'b1111}) begin
         n_fail++;
         $display("FAIL reset_state: hrq=%b gv=%b ch=%0d clr=%b dack=%b expected 0 0 0 0000 1111",
                  HRQ, grantValid, grantCh, reqClear, DACK);
      end
   endtask

   task automatic test_fixed();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      do_reset();
      DREQ = 4'b1010; exp_q.push_back(2'd1);
      @(negedge CLK);
      n_tests++;
      if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fixed_hrq_latency: hrq=%b expected 1", HRQ); end
      run_service(1, 3, 1'b0, ok, ch, dack);
      pop_cmp("fixed_grant", ok, ch);
      n_tests++;
      if (dack !== 4'b1101) begin n_fail++; $display("FAIL fixed_dack: dack=%b expected 1101", dack); end
      n_tests++;
      if ({HRQ, grantValid, DACK} !== {1'b0, 1'b0, 4'b1111}) begin
         n_fail++; $display("FAIL fixed_release: hrq=%b gv=%b dack=%b expected 0 0 1111", HRQ, grantValid, DACK);
      end
      DREQ = 4'b1100; exp_q.push_back(2'd2);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("fixed_grant_2", ok, ch);
      DREQ = '0;
   endtask

   task automatic test_rotate();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      do_reset();
      rotatingPri = 1'b1; DREQ = 4'b0011;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      run_service(0, 1, 1'b0, ok, ch, dack);
      pop_cmp("rotate_first", ok, ch);
      n_tests++;
      if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rotate_gap: hrq=%b expected 0", HRQ); end
      run_service(0, 1, 1'b0, ok, ch, dack);
      pop_cmp("rotate_second", ok, ch);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("rotate_lowpri_1", ok, ch);
      DREQ = '0;
   endtask

   task automatic test_withdraw();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      do_reset();
      rotatingPri = 1'b1; DREQ = 4'b0001;
      @(negedge CLK);
      DREQ = 4'b0000;
      @(negedge CLK);
      n_tests++;
      if ({HRQ, grantValid, DACK} !== {1'b0, 1'b0, 4'b1111}) begin
         n_fail++; $display("FAIL withdraw_idle: hrq=%b gv=%b dack=%b expected 0 0 1111", HRQ, grantValid, DACK);
      end
      DREQ = 4'b0011; exp_q.push_back(2'd0);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("withdraw_no_rotate", ok, ch);
      DREQ = '0;
   endtask

   task automatic test_soft_request_tc();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      do_reset();
      maskReg = 4'b0001; DREQ = 4'b0001; requestReg = 4'b0100; dackSenseHigh = 1'b1;
      exp_q.push_back(2'd2);
      run_service(0, 1, 1'b1, ok, ch, dack);
      pop_cmp("softreq_grant", ok, ch);
      n_tests++;
      if (dack !== 4'b0100) begin n_fail++; $display("FAIL softreq_dack: dack=%b expected 0100", dack); end
      n_tests++;
      if (reqClear !== 4'b0100 || DACK !== 4'b0000) begin
         n_fail++; $display("FAIL softreq_clear: clr=%b dack=%b expected 0100 0000", reqClear, DACK);
      end
      requestReg = '0; DREQ = '0;
      @(negedge CLK);
      n_tests++;
      if (reqClear !== 4'b0000) begin n_fail++; $display("FAIL softreq_clear_pulse: clr=%b expected 0000", reqClear); end
   endtask

   task automatic test_reset_in_service();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      int n;
      do_reset();
      rotatingPri = 1'b1; DREQ = 4'b0011; exp_q.push_back(2'd0);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("rst_pre_service", ok, ch);
      n = 0;
      while (HRQ !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      HLDA = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (grantValid !== 1'b1 || grantCh !== 2'd1) begin
         n_fail++; $display("FAIL rst_in_service_setup: gv=%b ch=%0d expected 1 1", grantValid, grantCh);
      end
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      n_tests++;
      if ({HRQ, grantValid, grantCh, DACK} !== {1'b0, 1'b0, 2'd0, 4'b1111}) begin
         n_fail++; $display("FAIL rst_in_service: hrq=%b gv=%b ch=%0d dack=%b expected 0 0 0 1111",
                            HRQ, grantValid, grantCh, DACK);
      end
      HLDA = 1'b0; exp_q.push_back(2'd0);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("rst_lowpri_3", ok, ch);
      DREQ = '0;
   endtask

   task automatic test_hlda_abort();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      int n;
      do_reset();
      rotatingPri = 1'b1; DREQ = 4'b0001;
      n = 0;
      while (HRQ !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      HLDA = 1'b1;
      @(negedge CLK);
      HLDA = 1'b0; DREQ = 4'b0011;
      @(negedge CLK);
      n_tests++;
      if ({HRQ, grantValid, DACK} !== {1'b0, 1'b0, 4'b1111}) begin
         n_fail++; $display("FAIL abort_idle: hrq=%b gv=%b dack=%b expected 0 0 1111", HRQ, grantValid, DACK);
      end
      @(negedge CLK);
      n_tests++;
      if (HRQ !== 1'b1) begin n_fail++; $display("FAIL abort_rearb: hrq=%b expected 1", HRQ); end
      exp_q.push_back(2'd0);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("abort_no_rotate", ok, ch);
      DREQ = '0;
   endtask

   task automatic test_disable_sense();
      logic ok; logic [CH_W-1:0] ch; logic [NUM_CH-1:0] dack;
      do_reset();
      ctrlDisable = 1'b1; DREQ = 4'b1111;
      repeat (3) @(negedge CLK);
      n_tests++;
      if (HRQ !== 1'b0) begin n_fail++; $display("FAIL disable_blocks: hrq=%b expected 0", HRQ); end
      ctrlDisable = 1'b0; dreqSenseLow = 1'b1; DREQ = 4'b0011; exp_q.push_back(2'd2);
      run_service(0, 0, 1'b0, ok, ch, dack);
      pop_cmp("dreq_active_low", ok, ch);
      DREQ = 4'b1111;
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_rotate();
      test_withdraw();
      test_soft_request_tc();
      test_reset_in_service();
      test_hlda_abort();
      test_disable_sense();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
